// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU selects, FSM states and decoded-control bundle
// for the multi-cycle CPU control unit.
package ctrl_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_BNE   = 8'h0C;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0] aluop;
        logic [2:0] rr1;
        logic [2:0] rr2;
        logic [2:0] wr;
        logic [7:0] imm;
        logic       imm_sel;
        logic       neg_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       br_jump;
        logic       br_eq;
        logic       br_ne;
    } ctrl_t;

    // Word-aligned relative target; wraps modulo 2^32.
    function automatic logic [31:0] branch_target(
        input logic [31:0] pc,
        input logic [7:0]  off
    );
        return pc + 32'd4 + {{22{off[7]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational opcode decoder producing the control bundle.
// bne (opcode 0C) is decoded only when CTRL_BNE_EN is defined.
module cpu_instr_decoder
    import ctrl_pkg::*;
(
    input  logic [7:0] i_op,
    input  logic [2:0] i_rd,
    input  logic [2:0] i_rt,
    input  logic [7:0] i_rs,
    output ctrl_t      o_ctl,
    output logic       o_illegal
);

    always_comb begin
        o_ctl     = '0;
        o_illegal = 1'b0;
        unique case (i_op)
            OP_LOADI: begin
                o_ctl.wr      = i_rd;
                o_ctl.imm     = i_rs;
                o_ctl.imm_sel = 1'b1;
                o_ctl.reg_wr  = 1'b1;
            end
            OP_MOV: begin
                o_ctl.rr2    = i_rs[2:0];
                o_ctl.wr     = i_rd;
                o_ctl.reg_wr = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_ctl.aluop   = (i_op == OP_AND) ? ALU_AND :
                                (i_op == OP_OR)  ? ALU_OR  : ALU_ADD;
                o_ctl.neg_sel = (i_op == OP_SUB);
                o_ctl.rr1     = i_rs[2:0];
                o_ctl.rr2     = i_rt;
                o_ctl.wr      = i_rd;
                o_ctl.reg_wr  = 1'b1;
            end
            OP_J: begin
                o_ctl.br_jump = 1'b1;
            end
            OP_BEQ: begin
                o_ctl.aluop   = ALU_ADD;
                o_ctl.neg_sel = 1'b1;
                o_ctl.rr1     = i_rs[2:0];
                o_ctl.rr2     = i_rt;
                o_ctl.br_eq   = 1'b1;
            end
            OP_LWD: begin
                o_ctl.rr2        = i_rs[2:0];
                o_ctl.wr         = i_rd;
                o_ctl.mem_rd     = 1'b1;
                o_ctl.mem_to_reg = 1'b1;
                o_ctl.reg_wr     = 1'b1;
            end
            OP_LWI: begin
                o_ctl.imm        = i_rs;
                o_ctl.imm_sel    = 1'b1;
                o_ctl.wr         = i_rd;
                o_ctl.mem_rd     = 1'b1;
                o_ctl.mem_to_reg = 1'b1;
                o_ctl.reg_wr     = 1'b1;
            end
            // Stores read the data register on port 1, address on port 2.
            OP_SWD: begin
                o_ctl.rr1    = i_rt;
                o_ctl.rr2    = i_rs[2:0];
                o_ctl.mem_wr = 1'b1;
            end
            OP_SWI: begin
                o_ctl.rr1     = i_rt;
                o_ctl.imm     = i_rs;
                o_ctl.imm_sel = 1'b1;
                o_ctl.mem_wr  = 1'b1;
            end
`ifdef CTRL_BNE_EN
            OP_BNE: begin
                o_ctl.aluop   = ALU_ADD;
                o_ctl.neg_sel = 1'b1;
                o_ctl.rr1     = i_rs[2:0];
                o_ctl.rr2     = i_rt;
                o_ctl.br_ne   = 1'b1;
            end
`endif
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the 8-bit CPU.
// Optional bne support is enabled by defining CTRL_BNE_EN.
module cpu_control_unit
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        I_BUSYWAIT,
    input  logic        D_BUSYWAIT,
    input  logic        ZERO,
    output logic [31:0] PC,
    output logic [2:0]  ALUOP,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic [7:0]  IMMEDIATE,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic        REG_WRITE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        MEM_TO_REG,
    output logic        ILLEGAL
);

    state_e      r_state;
    logic [31:0] r_pc;
    ctrl_t       r_ctl;
    logic [7:0]  r_off;
    logic        r_take;
    logic        r_reg_wr;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_illegal;

    ctrl_t       w_dec;
    logic        w_dec_illegal;
    logic        w_unused;

    assign w_unused = ^INSTRUCTION[15:11];

    cpu_instr_decoder u_dec (
        .i_op      (INSTRUCTION[31:24]),
        .i_rd      (INSTRUCTION[18:16]),
        .i_rt      (INSTRUCTION[10:8]),
        .i_rs      (INSTRUCTION[7:0]),
        .o_ctl     (w_dec),
        .o_illegal (w_dec_illegal)
    );

    // Decoded controls are loaded on the edge into DECODE and held
    // until the instruction retires, so the ALU path stays stable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_ctl     <= '0;
            r_off     <= '0;
            r_take    <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (!I_BUSYWAIT) begin
                        r_ctl     <= w_dec;
                        r_off     <= INSTRUCTION[23:16];
                        r_illegal <= r_illegal | w_dec_illegal;
                        r_state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    r_take <= r_ctl.br_jump
                            | (r_ctl.br_eq & ZERO)
                            | (r_ctl.br_ne & ~ZERO);
                    if (r_ctl.mem_rd || r_ctl.mem_wr) begin
                        r_mem_rd <= r_ctl.mem_rd;
                        r_mem_wr <= r_ctl.mem_wr;
                        r_state  <= ST_MEM;
                    end else begin
                        r_reg_wr <= r_ctl.reg_wr;
                        r_state  <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (!D_BUSYWAIT) begin
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_reg_wr <= r_ctl.reg_wr;
                        r_state  <= ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    r_pc     <= r_take ? branch_target(r_pc, r_off)
                                       : r_pc + 32'd4;
                    r_ctl    <= '0;
                    r_take   <= 1'b0;
                    r_reg_wr <= 1'b0;
                    r_state  <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign PC         = r_pc;
    assign ALUOP      = r_ctl.aluop;
    assign READREG1   = r_ctl.rr1;
    assign READREG2   = r_ctl.rr2;
    assign WRITEREG   = r_ctl.wr;
    assign IMMEDIATE  = r_ctl.imm;
    assign IMM_SEL    = r_ctl.imm_sel;
    assign NEG_SEL    = r_ctl.neg_sel;
    assign MEM_TO_REG = r_ctl.mem_to_reg;
    assign REG_WRITE  = r_reg_wr;
    assign MEM_READ   = r_mem_rd;
    assign MEM_WRITE  = r_mem_wr;
    assign ILLEGAL    = r_illegal;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        ibusy;
    logic        dbusy;
    logic        zero;
    logic [31:0] pc;
    logic [2:0]  aluop;
    logic [2:0]  rr1;
    logic [2:0]  rr2;
    logic [2:0]  wr;
    logic [7:0]  imm;
    logic        imm_sel;
    logic        neg_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        illegal;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] pc_m;

    always #5 clk = ~clk;

    cpu_control_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .INSTRUCTION (instr),
        .I_BUSYWAIT  (ibusy),
        .D_BUSYWAIT  (dbusy),
        .ZERO        (zero),
        .PC          (pc),
        .ALUOP       (aluop),
        .READREG1    (rr1),
        .READREG2    (rr2),
        .WRITEREG    (wr),
        .IMMEDIATE   (imm),
        .IMM_SEL     (imm_sel),
        .NEG_SEL     (neg_sel),
        .REG_WRITE   (reg_write),
        .MEM_READ    (mem_read),
        .MEM_WRITE   (mem_write),
        .MEM_TO_REG  (mem_to_reg),
        .ILLEGAL     (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Non-memory instruction with no stalls: FETCH, DECODE, EXECUTE, WRITEBACK.
    task automatic do_alu(input string tag, input logic [31:0] ins,
                          input logic z, input logic [2:0] e_op,
                          input logic [2:0] e_r1, input logic [2:0] e_r2,
                          input logic [2:0] e_wr, input logic [7:0] e_imm,
                          input logic e_is, input logic e_ns,
                          input logic e_rw, input logic [31:0] e_pc);
        instr = ins;
        zero  = z;
        step();
        chk({tag, ".dec.aluop"}, 32'(aluop), 32'(e_op));
        chk({tag, ".dec.rr1"}, 32'(rr1), 32'(e_r1));
        chk({tag, ".dec.rr2"}, 32'(rr2), 32'(e_r2));
        chk({tag, ".dec.wr"}, 32'(wr), 32'(e_wr));
        chk({tag, ".dec.imm"}, 32'(imm), 32'(e_imm));
        chk({tag, ".dec.imm_sel"}, 32'(imm_sel), 32'(e_is));
        chk({tag, ".dec.neg_sel"}, 32'(neg_sel), 32'(e_ns));
        chk({tag, ".dec.mem"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({tag, ".dec.rw"}, 32'(reg_write), 32'd0);
        step();
        chk({tag, ".ex.aluop"}, 32'(aluop), 32'(e_op));
        chk({tag, ".ex.rw"}, 32'(reg_write), 32'd0);
        chk({tag, ".ex.pc"}, pc, pc_m);
        step();
        chk({tag, ".wb.rw"}, 32'(reg_write), 32'(e_rw));
        chk({tag, ".wb.pc"}, pc, pc_m);
        step();
        chk({tag, ".f.rw"}, 32'(reg_write), 32'd0);
        chk({tag, ".f.aluop"}, 32'(aluop), 32'd0);
        chk({tag, ".f.pc"}, pc, e_pc);
        pc_m = e_pc;
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h0;
        ibusy = 1'b0;
        dbusy = 1'b0;
        zero  = 1'b0;
        pc_m  = 32'h0;
        step();
        step();
        chk("rst.pc", pc, 32'h0);
        chk("rst.aluop", 32'(aluop), 32'd0);
        chk("rst.addr", {23'd0, rr1, rr2, wr}, 32'd0);
        chk("rst.imm", 32'(imm), 32'd0);
        chk("rst.bits", {25'd0, imm_sel, neg_sel, reg_write,
                         mem_read, mem_write, mem_to_reg, illegal}, 32'd0);

        rst = 1'b0;
        do_alu("add", 32'h02_03_01_02, 1'b0, 3'b001, 3'd2, 3'd1, 3'd3,
               8'h00, 1'b0, 1'b0, 1'b1, 32'h4);

`ifdef CTRL_BNE_EN
        do_alu("bne", 32'h0C_02_01_02, 1'b0, 3'b001, 3'd2, 3'd1, 3'd0,
               8'h00, 1'b0, 1'b1, 1'b0, 32'h10);
        chk("bne.illegal", 32'(illegal), 32'd0);
`else
        do_alu("op0c", 32'h0C_02_01_02, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0,
               8'h00, 1'b0, 1'b0, 1'b0, 32'h8);
        chk("op0c.illegal", 32'(illegal), 32'd1);
`endif

        rst = 1'b1;
        step();
        chk("rst2.pc", pc, 32'h0);
        chk("rst2.illegal", 32'(illegal), 32'd0);
        rst  = 1'b0;
        pc_m = 32'h0;

        do_alu("sub", 32'h03_05_06_07, 1'b0, 3'b001, 3'd7, 3'd6, 3'd5,
               8'h00, 1'b0, 1'b1, 1'b1, 32'h4);
        do_alu("loadi", 32'h00_04_00_5A, 1'b0, 3'b000, 3'd0, 3'd0, 3'd4,
               8'h5A, 1'b1, 1'b0, 1'b1, 32'h8);
        do_alu("ill3f", 32'h3F_07_07_07, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0,
               8'h00, 1'b0, 1'b0, 1'b0, 32'hC);
        chk("ill3f.illegal", 32'(illegal), 32'd1);

        // lwi with data memory stalled for three MEM cycles
        instr = 32'h09_06_00_20;
        step();
        chk("lwi.dec.imm", 32'(imm), 32'h20);
        chk("lwi.dec.imm_sel", 32'(imm_sel), 32'd1);
        chk("lwi.dec.aluop", 32'(aluop), 32'd0);
        chk("lwi.dec.wr", 32'(wr), 32'd6);
        chk("lwi.dec.m2r", 32'(mem_to_reg), 32'd1);
        chk("lwi.dec.mrd", 32'(mem_read), 32'd0);
        step();
        chk("lwi.ex.mrd", 32'(mem_read), 32'd0);
        dbusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("lwi.mem%0d.mrd", i), 32'(mem_read), 32'd1);
            chk($sformatf("lwi.mem%0d.rw", i), 32'(reg_write), 32'd0);
            chk($sformatf("lwi.mem%0d.mwr", i), 32'(mem_write), 32'd0);
            if (i == 3) dbusy = 1'b0;
        end
        step();
        chk("lwi.wb.rw", 32'(reg_write), 32'd1);
        chk("lwi.wb.mrd", 32'(mem_read), 32'd0);
        chk("lwi.wb.m2r", 32'(mem_to_reg), 32'd1);
        chk("lwi.wb.pc", pc, 32'hC);
        step();
        chk("lwi.f.rw", 32'(reg_write), 32'd0);
        chk("lwi.f.m2r", 32'(mem_to_reg), 32'd0);
        chk("lwi.f.pc", pc, 32'h10);
        pc_m = 32'h10;

        do_alu("beq_t", 32'h07_FE_01_02, 1'b1, 3'b001, 3'd2, 3'd1, 3'd0,
               8'h00, 1'b0, 1'b1, 1'b0, 32'hC);
        do_alu("beq_n1", 32'h07_FE_01_02, 1'b0, 3'b001, 3'd2, 3'd1, 3'd0,
               8'h00, 1'b0, 1'b1, 1'b0, 32'h10);
        do_alu("beq_n2", 32'h07_FE_01_02, 1'b0, 3'b001, 3'd2, 3'd1, 3'd0,
               8'h00, 1'b0, 1'b1, 1'b0, 32'h14);

        // instruction memory stalled for five cycles
        ibusy = 1'b1;
        instr = 32'h04_02_03_01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("istall%0d.aluop", i), 32'(aluop), 32'd0);
            chk($sformatf("istall%0d.addr", i), {23'd0, rr1, rr2, wr}, 32'd0);
            chk($sformatf("istall%0d.bits", i), {28'd0, reg_write, mem_read,
                                                 mem_write, imm_sel}, 32'd0);
            chk($sformatf("istall%0d.pc", i), pc, 32'h14);
        end
        ibusy = 1'b0;
        do_alu("and", 32'h04_02_03_01, 1'b0, 3'b010, 3'd1, 3'd3, 3'd2,
               8'h00, 1'b0, 1'b0, 1'b1, 32'h18);

        do_alu("j", 32'h06_02_00_00, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0,
               8'h00, 1'b0, 1'b0, 1'b0, 32'h24);

        // swd interrupted by reset during its MEM stall
        instr = 32'h0A_00_03_04;
        step();
        chk("swd.dec.rr1", 32'(rr1), 32'd3);
        chk("swd.dec.rr2", 32'(rr2), 32'd4);
        chk("swd.dec.mwr", 32'(mem_write), 32'd0);
        step();
        dbusy = 1'b1;
        step();
        chk("swd.mem0.mwr", 32'(mem_write), 32'd1);
        chk("swd.mem0.mrd", 32'(mem_read), 32'd0);
        step();
        chk("swd.mem1.mwr", 32'(mem_write), 32'd1);
        rst = 1'b1;
        step();
        chk("swd.rst.mwr", 32'(mem_write), 32'd0);
        chk("swd.rst.rw", 32'(reg_write), 32'd0);
        chk("swd.rst.pc", pc, 32'h0);
        chk("swd.rst.illegal", 32'(illegal), 32'd0);
        chk("swd.rst.rr1", 32'(rr1), 32'd0);
        rst   = 1'b0;
        dbusy = 1'b0;
        pc_m  = 32'h0;

        do_alu("jwrap", 32'h06_FE_00_00, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0,
               8'h00, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        do_alu("or", 32'h05_01_02_03, 1'b0, 3'b011, 3'd3, 3'd2, 3'd1,
               8'h00, 1'b0, 1'b0, 1'b1, 32'h0);
        do_alu("mov", 32'h01_02_00_05, 1'b0, 3'b000, 3'd0, 3'd5, 3'd2,
               8'h00, 1'b0, 1'b0, 1'b1, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
